// File: rtl/al4s3b_wb_aperture_mux.sv
// Wishbone aperture decoder for the host bus.
// Splits the host address space into NUM_SLAVES fixed windows, drives one
// chip select per window and forwards the selected slave's acknowledge and
// read data. Accesses that nobody answers are acknowledged after TIMEOUT wait
// cycles with DEFAULT_READ_VALUE. Every such timeout is logged in a
// saturating counter, an address register and a one-cycle pulse.
module al4s3b_wb_aperture_mux #(
    parameter int                              NUM_SLAVES         = 4,
    parameter int                              APERWIDTH          = 17,
    parameter int                              APERSIZE           = 11,
    parameter int                              DATAWIDTH          = 32,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS         = {17'h06000, 17'h04000, 17'h02000, 17'h00000},
    parameter logic [DATAWIDTH-1:0]            DEFAULT_READ_VALUE = 32'hBAD_FAB_AC,
    parameter int                              CNTR_WIDTH         = 4,
    parameter int                              TIMEOUT            = 7
) (
    input  logic                             WBs_CLK_i,
    input  logic                             WBs_RST_i,
    input  logic [APERWIDTH-1:0]             WBs_ADR_i,
    input  logic                             WBs_CYC_i,
    input  logic                             WBs_STB_i,
    output logic [NUM_SLAVES-1:0]            WBs_CYC_o,
    input  logic [NUM_SLAVES-1:0]            WBs_ACK_i,
    input  logic [NUM_SLAVES*DATAWIDTH-1:0]  WBs_SLV_DAT_i,
    output logic [DATAWIDTH-1:0]             WBs_RD_DAT_o,
    output logic                             WBs_ACK_o,
    output logic [7:0]                       ERR_CNT_o,
    output logic [APERWIDTH-1:0]             ERR_ADR_o,
    output logic                             ERR_PULSE_o
);

    // Lowest address bit that takes part in the window compare.
    localparam int                    TAG_LSB     = APERSIZE + 2;
    localparam int                    TAG_WIDTH   = APERWIDTH - TAG_LSB;
    localparam logic [CNTR_WIDTH-1:0] TIMEOUT_CNT = CNTR_WIDTH'(TIMEOUT);
    localparam logic [7:0]            ERR_CNT_MAX = 8'hFF;

    // IDLE waits for a strobe, COUNT waits for the slave, TOACK is the
    // single forced-acknowledge cycle after a timeout.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        TOACK = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNTR_WIDTH-1:0]   cnt_q;
    logic [CNTR_WIDTH-1:0]   cnt_d;
    logic [7:0]              err_cnt_q;
    logic [7:0]              err_cnt_d;
    logic [APERWIDTH-1:0]    err_adr_q;
    logic                    err_pulse_q;

    logic [NUM_SLAVES-1:0]   match;
    logic [NUM_SLAVES-1:0]   sel;
    logic                    mapped;
    logic                    strobe;
    logic                    slave_ack;
    logic                    in_toack;

    // Compare the tag bits of the host address against every window base.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // before any conditional code, otherwise synthesis infers a latch.
        match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = (WBs_ADR_i[APERWIDTH-1:TAG_LSB] ==
                        BASE_ADDRS[i*APERWIDTH + TAG_LSB +: TAG_WIDTH]);
        end
    end

    // Reduce overlapping matches to one-hot; walking downwards lets the
    // lowest matching index overwrite any higher one.
    always_comb begin
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign mapped    = |sel;
    assign strobe    = WBs_CYC_i & WBs_STB_i;
    assign slave_ack = |(WBs_ACK_i & sel);
    assign in_toack  = (state_q == TOACK);

    // Chip selects follow the address combinationally. They are dropped
    // during the forced-ack cycle so a late slave cannot answer it.
    assign WBs_CYC_o = sel & {NUM_SLAVES{WBs_CYC_i & ~in_toack}};

    // The host acknowledge is either the forced timeout ack or the selected
    // slave's ack. Acks from unselected windows never reach the host.
    assign WBs_ACK_o = ~WBs_RST_i &
                       (in_toack | (slave_ack & ~in_toack & strobe));

    // Steer the selected window's read data, or the fallback value for
    // timeouts and unmapped addresses.
    always_comb begin
        WBs_RD_DAT_o = DEFAULT_READ_VALUE;
        if (mapped && !in_toack) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel[i]) begin
                    WBs_RD_DAT_o = WBs_SLV_DAT_i[i*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

    // Next values for the wait counter and the saturating error counter.
    always_comb begin
        cnt_d     = cnt_q + CNTR_WIDTH'(1);
        err_cnt_d = (err_cnt_q == ERR_CNT_MAX) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    // Access-tracking FSM with the registered timeout log.
    always_ff @(posedge WBs_CLK_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (WBs_RST_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_cnt_q   <= '0;
            err_adr_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A same-cycle slave ack completes the access here.
                    if (strobe && !slave_ack) begin
                        state_q <= COUNT;
                        cnt_q   <= CNTR_WIDTH'(1);
                    end
                end
                COUNT: begin
                    // Host abort and slave ack both beat the timeout, so
                    // a slave answering on the last wait cycle still wins.
                    if (!strobe || slave_ack) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        state_q     <= TOACK;
                        err_pulse_q <= 1'b1;
                        err_adr_q   <= WBs_ADR_i;
                        err_cnt_q   <= err_cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                TOACK: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ERR_CNT_o   = err_cnt_q;
    assign ERR_ADR_o   = err_adr_q;
    assign ERR_PULSE_o = err_pulse_q;

endmodule

// File: tb/tb_al4s3b_wb_aperture_mux.sv
// Scoreboard bench for al4s3b_wb_aperture_mux.
// The driver plans each access from the decode and timeout rules. It pushes
// the expected response (latency, data, error log) into a queue and then
// plays the access. A separate monitor pops one entry each time the host
// acknowledge rises.
module tb_al4s3b_wb_aperture_mux;

    localparam int          NS    = 4;
    localparam int          AW    = 17;
    localparam int          DW    = 32;
    localparam int          TO    = 7;
    localparam logic [31:0] DFLT  = 32'hBADFABAC;

    typedef struct {
        int          lat;
        logic [31:0] data;
        bit          err;
        logic [16:0] err_adr;
        logic [7:0]  err_cnt;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     adr;
    logic              cyc;
    logic              stb;
    logic [NS-1:0]     cyc_o;
    logic [NS-1:0]     ack_i;
    logic [NS*DW-1:0]  slv_dat;
    logic [DW-1:0]     rd_dat;
    logic              ack_o;
    logic [7:0]        err_cnt;
    logic [AW-1:0]     err_adr;
    logic              err_pulse;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   m_err_cnt = 0;
    logic [16:0] m_err_adr = '0;
    int   base_tbl [4] = '{'h00000, 'h02000, 'h04000, 'h06000};
    int   mon_count = 0;

    al4s3b_wb_aperture_mux dut (
        .WBs_CLK_i     (clk),
        .WBs_RST_i     (rst),
        .WBs_ADR_i     (adr),
        .WBs_CYC_i     (cyc),
        .WBs_STB_i     (stb),
        .WBs_CYC_o     (cyc_o),
        .WBs_ACK_i     (ack_i),
        .WBs_SLV_DAT_i (slv_dat),
        .WBs_RD_DAT_o  (rd_dat),
        .WBs_ACK_o     (ack_o),
        .ERR_CNT_o     (err_cnt),
        .ERR_ADR_o     (err_adr),
        .ERR_PULSE_o   (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window index: the 8 KB block number of the address equals a base's block number.
    function automatic int win_of(input logic [16:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((int'(a) / 'h2000) == (base_tbl[i] / 'h2000)) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] sel_of(input logic [16:0] a);
        logic [3:0] s;
        int w;
        s = '0;
        w = win_of(a);
        if (w >= 0) s[w] = 1'b1;
        return s;
    endfunction

    function automatic logic [16:0] rand_addr();
        int blk;
        int low;
        if ($urandom_range(0, 9) < 6) blk = base_tbl[$urandom_range(0, 3)] / 'h2000;
        else                          blk = int'($urandom_range(4, 15));
        low = int'($urandom_range(0, 8191));
        return 17'(blk * 'h2000 + low);
    endfunction

    // One host access. a0 is used until cycle c, a1 from then on (c<0: no
    // change). The window addressed in cycle d acks there (d<0: nobody acks).
    task automatic run_txn(input logic [16:0] a0, input int c, input logic [16:0] a1,
                           input int d, input logic [31:0] dat,
                           input logic [3:0] force_noise, input bit rnd_noise);
        exp_t        e;
        exp_t        junk;
        int          w;
        bit          got;
        logic [16:0] a;
        logic [3:0]  nz;
        w = -1;
        if (d >= 0) w = win_of((c >= 0 && d >= c) ? a1 : a0);
        if (d >= 0 && d <= TO && w >= 0) begin
            e.lat  = d;
            e.data = dat;
            e.err  = 1'b0;
        end else begin
            e.lat     = TO + 1;
            e.data    = DFLT;
            e.err     = 1'b1;
            m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
            m_err_adr = (c >= 0 && TO >= c) ? a1 : a0;
        end
        e.err_cnt = 8'(m_err_cnt);
        e.err_adr = m_err_adr;
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k <= TO + 3 && !got; k++) begin
            a = (c >= 0 && k >= c) ? a1 : a0;
            @(posedge clk);
            #1;
            adr = a;
            cyc = 1'b1;
            stb = 1'b1;
            nz  = (force_noise | (rnd_noise ? 4'($urandom) : 4'b0)) & ~sel_of(a);
            ack_i = nz;
            for (int j = 0; j < NS; j++) slv_dat[j*DW +: DW] = $urandom;
            if (k == d && w >= 0) begin
                ack_i[w]            = 1'b1;
                slv_dat[w*DW +: DW] = dat;
            end
            @(negedge clk);
            if (ack_o) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_no_ack: adr %0h got no ack within %0d cycles", a0, TO + 4);
            if (exp_q.size() > 0) junk = exp_q.pop_front();
        end
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc   = 1'b0;
            stb   = 1'b0;
            ack_i = '0;
            @(negedge clk);
        end
    endtask

    // Host holds the strobe for cycles 0..2 and drops it in cycle 3 (cnt==3).
    task automatic abort_txn(input logic [16:0] a);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            adr   = a;
            ack_i = '0;
            cyc   = (k < 3);
            stb   = (k < 3);
            @(negedge clk);
        end
    endtask

    // Window-1 access; reset rises in cycle 4 (cnt==4) while the slave acks.
    task automatic reset_mid_txn();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            adr   = 17'h02004;
            cyc   = (k <= 4);
            stb   = (k <= 4);
            rst   = (k == 4);
            ack_i = (k == 4) ? 4'b0010 : 4'b0000;
            for (int j = 0; j < NS; j++) slv_dat[j*DW +: DW] = $urandom;
            @(negedge clk);
        end
        m_err_cnt = 0;
        m_err_adr = '0;
    endtask

    // Monitor: cycle-by-cycle checks, popping the scoreboard on every ack.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("ack_during_reset", {63'b0, ack_o}, 64'd0);
            mon_count = 0;
        end else if (cyc && stb) begin
            check("cyc_o", {60'b0, cyc_o}, {60'b0, (mon_count == TO + 1) ? 4'b0 : sel_of(adr)});
            if (ack_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: adr %0h cycle %0d, nothing expected", adr, mon_count);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_latency", 64'(mon_count), 64'(e.lat));
                    check("rd_dat", {32'b0, rd_dat}, {32'b0, e.data});
                    check("err_pulse", {63'b0, err_pulse}, {63'b0, e.err});
                    check("err_cnt", {56'b0, err_cnt}, {56'b0, e.err_cnt});
                    check("err_adr", {47'b0, err_adr}, {47'b0, e.err_adr});
                end
                mon_count = 0;
            end else begin
                check("err_pulse_quiet", {63'b0, err_pulse}, 64'd0);
                if (mon_count < 100) mon_count++;
            end
        end else begin
            check("ack_without_cyc", {63'b0, ack_o}, 64'd0);
            check("cyc_o_idle", {60'b0, cyc_o}, 64'd0);
            mon_count = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] a0;
        logic [16:0] a1;
        int          c;
        int          d;
        rst     = 1'b1;
        adr     = '0;
        cyc     = 1'b0;
        stb     = 1'b0;
        ack_i   = '0;
        slv_dat = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_err_cnt", {56'b0, err_cnt}, 64'd0);
        check("reset_err_adr", {47'b0, err_adr}, 64'd0);
        check("reset_err_pulse", {63'b0, err_pulse}, 64'd0);
        check("reset_ack", {63'b0, ack_o}, 64'd0);

        // Window 1 read, slave answers in the second cycle.
        run_txn(17'h02004, -1, 17'h0, 1, 32'h12345678, 4'b0, 1'b0);
        check("win1_err_cnt", {56'b0, err_cnt}, 64'd0);
        // Unmapped read times out with the fallback data.
        run_txn(17'h1E000, -1, 17'h0, -1, 32'h0, 4'b0, 1'b0);
        check("unmapped_err_cnt", {56'b0, err_cnt}, 64'd1);
        check("unmapped_err_adr", {47'b0, err_adr}, 64'h1E000);
        // Slave ack on the last wait cycle wins over the timeout.
        run_txn(17'h00010, -1, 17'h0, TO, 32'hCAFE0007, 4'b0, 1'b1);
        check("late_ack_err_cnt", {56'b0, err_cnt}, 64'd1);
        // Window edges, an ack in the first cycle and the first unmapped block.
        run_txn(17'h01FFF, -1, 17'h0, 2, 32'h0000F00D, 4'b0, 1'b1);
        run_txn(17'h07FFF, -1, 17'h0, 3, 32'h33333333, 4'b0, 1'b1);
        run_txn(17'h00000, -1, 17'h0, 0, 32'hA5A5A5A5, 4'b0, 1'b1);
        run_txn(17'h08000, -1, 17'h0, -1, 32'h0, 4'b0, 1'b0);
        // Host abort at cnt==3, then a fresh timeout must take the full count.
        abort_txn(17'h1E004);
        run_txn(17'h1E008, -1, 17'h0, -1, 32'h0, 4'b0, 1'b0);
        // Address moves mid-access: select follows, the count keeps running.
        run_txn(17'h00100, 3, 17'h04100, 5, 32'h44440005, 4'b0, 1'b1);
        run_txn(17'h00100, 4, 17'h1E000, -1, 32'h0, 4'b0, 1'b0);
        // Window 3 never answers; window 2 acks all the time and must be ignored.
        for (int n = 0; n < 300; n++) begin
            run_txn(17'(32'h06000 + $urandom_range(0, 8191)), -1, 17'h0, -1, 32'h0, 4'b0100, 1'b0);
        end
        bus_idle(1);
        check("err_cnt_saturated", {56'b0, err_cnt}, 64'd255);
        // Reset in the middle of a wait, then a normal access.
        reset_mid_txn();
        check("mid_reset_err_cnt", {56'b0, err_cnt}, 64'd0);
        check("mid_reset_err_adr", {47'b0, err_adr}, 64'd0);
        check("mid_reset_err_pulse", {63'b0, err_pulse}, 64'd0);
        run_txn(17'h02004, -1, 17'h0, 1, 32'h12345678, 4'b0, 1'b0);
        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            a0 = rand_addr();
            a1 = rand_addr();
            c  = -1;
            if ($urandom_range(0, 3) == 0) c = int'($urandom_range(1, TO - 1));
            d  = -1;
            if ($urandom_range(0, 9) < 7) d = int'($urandom_range(0, TO));
            run_txn(a0, c, a1, d, $urandom, 4'b0, 1'($urandom_range(0, 1)));
        end
        bus_idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
